// File: rtl/lights_sequencer.sv
// rtl/lights_sequencer.sv - button debounce, WHITE/MANUAL/AUTO mode FSM and step pulse scheduler
module lights_sequencer #(
    parameter int DWELL_CYCLES = 8,
    parameter int DEBOUNCE     = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_step,
    input  logic             pause,
    output logic             sel,
    output logic             button,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int TM_W = $clog2(DWELL_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WHITE  = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DB_W-1:0]   mode_db_q, mode_db_d;
    logic [DB_W-1:0]   step_db_q, step_db_d;
    logic              mode_press_q, mode_press_d;
    logic              step_press_q, step_press_d;
    logic [TM_W-1:0]   timer_q, timer_d;
    logic              button_q, button_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Mode button debounce: counter saturates at DEBOUNCE so a held button presses once
    always_comb begin
        mode_db_d    = mode_db_q;
        mode_press_d = 1'b0;
        if (!btn_mode) begin
            mode_db_d = '0;
        end else if (mode_db_q != DB_MAX) begin
            mode_db_d    = mode_db_q + 1'b1;
            mode_press_d = (mode_db_q == DB_MAX - 1'b1);
        end
    end

    // Step button debounce, identical scheme to the mode button
    always_comb begin
        step_db_d    = step_db_q;
        step_press_d = 1'b0;
        if (!btn_step) begin
            step_db_d = '0;
        end else if (step_db_q != DB_MAX) begin
            step_db_d    = step_db_q + 1'b1;
            step_press_d = (step_db_q == DB_MAX - 1'b1);
        end
    end

    // Next state, dwell timer and step pulse; a mode press pre-empts any step that cycle
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        button_d = 1'b0;
        cnt_d    = cnt_q;
        if (mode_press_q) begin
            timer_d = '0;
            case (state_q)
                ST_WHITE:  state_d = ST_MANUAL;
                ST_MANUAL: state_d = ST_AUTO;
                default:   state_d = ST_WHITE;
            endcase
        end else begin
            case (state_q)
                ST_MANUAL: begin
                    timer_d  = '0;
                    button_d = step_press_q;
                end
                ST_AUTO: begin
                    if (step_press_q) begin
                        timer_d  = '0;
                        button_d = 1'b1;
                    end else if (!pause) begin
                        if (timer_q == TM_LAST) begin
                            timer_d  = '0;
                            // guards back-to-back pulses when DWELL_CYCLES is tiny
                            button_d = !button_q;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                ST_WHITE: timer_d = '0;
                default: begin
                    state_d = ST_WHITE;
                    timer_d = '0;
                end
            endcase
        end
        if (button_d) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (mode_press_q && state_d == ST_WHITE) begin
            cnt_d = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WHITE;
            mode_db_q    <= '0;
            step_db_q    <= '0;
            mode_press_q <= 1'b0;
            step_press_q <= 1'b0;
            timer_q      <= '0;
            button_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mode_db_q    <= mode_db_d;
            step_db_q    <= step_db_d;
            mode_press_q <= mode_press_d;
            step_press_q <= step_press_d;
            timer_q      <= timer_d;
            button_q     <= button_d;
            cnt_q        <= cnt_d;
        end
    end

    assign sel      = (state_q != ST_WHITE);
    assign mode     = state_q;
    assign button   = button_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_lights_sequencer.sv
// tb/tb_lights_sequencer.sv - directed self-checking bench for lights_sequencer
module tb_lights_sequencer;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_step;
    logic       pause;
    logic       sel;
    logic       button;
    logic [1:0] mode;
    logic [7:0] step_cnt;

    int checks;
    int errors;

    lights_sequencer #(
        .DWELL_CYCLES(8),
        .DEBOUNCE    (3),
        .CNT_W       (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_mode(btn_mode),
        .btn_step(btn_step),
        .pause   (pause),
        .sel     (sel),
        .button  (button),
        .mode    (mode),
        .step_cnt(step_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs at a falling edge, then advance over one rising edge
    task automatic step_edge(input logic m, input logic s, input logic p);
        btn_mode = m;
        btn_step = s;
        pause    = p;
        @(negedge clk);
    endtask

    initial begin
        int first;
        int last;
        int pulses;
        int changes;
        int bad;
        int prev_mode;
        int prev_btn;
        logic s;

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        btn_mode = 1'b1;
        btn_step = 1'b1;
        pause    = 1'b0;
        @(negedge clk);

        // 1: reset holds everything at zero even with both buttons held
        for (int i = 0; i < 5; i++) begin
            step_edge(1, 1, 0);
            check("reset_outputs", int'({sel, button, mode, step_cnt}), 0);
        end
        rst = 1'b0;
        step_edge(0, 0, 0);
        step_edge(0, 0, 0);

        // 2: short glitch rejected, long hold advances mode exactly once
        step_edge(1, 0, 0);
        step_edge(1, 0, 0);
        for (int i = 0; i < 4; i++) step_edge(0, 0, 0);
        check("glitch_mode", int'(mode), 0);
        first = 0; changes = 0; prev_mode = int'(mode);
        for (int i = 1; i <= 20; i++) begin
            step_edge(1, 0, 0);
            if (int'(mode) != prev_mode) begin
                changes++;
                if (first == 0) first = i;
            end
            prev_mode = int'(mode);
        end
        check("mode_latency", first, 4);
        check("mode_changes", changes, 1);
        check("mode_manual", int'(mode), 1);
        check("sel_manual", int'(sel), 1);
        step_edge(0, 0, 0);
        step_edge(0, 0, 0);

        // 3: manual step, one pulse per held press
        first = 0; pulses = 0; bad = 0; prev_btn = 0;
        for (int i = 1; i <= 10; i++) begin
            step_edge(0, 1, 0);
            if (button) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (button && prev_btn == 1) bad++;
            prev_btn = int'(button);
        end
        check("manual_latency", first, 4);
        check("manual_pulses", pulses, 1);
        check("manual_cnt1", int'(step_cnt), 1);
        step_edge(0, 0, 0);
        step_edge(0, 0, 0);
        for (int i = 0; i < 5; i++) step_edge(0, 1, 0);
        step_edge(0, 0, 0);
        check("manual_cnt2", int'(step_cnt), 2);
        check("manual_no_b2b", bad, 0);

        // 4: AUTO pulses every 8 cycles, then pause freezes the timer
        for (int i = 0; i < 4; i++) step_edge(1, 0, 0);
        check("mode_auto", int'(mode), 2);
        first = 0; last = 0; pulses = 0; bad = 0;
        for (int i = 1; i <= 40; i++) begin
            step_edge(0, 0, 0);
            if (button) begin
                if (last != 0 && i - last != 8) bad++;
                pulses++;
                if (first == 0) first = i;
                last = i;
            end
        end
        check("auto_pulses", pulses, 5);
        check("auto_first", first, 8);
        check("auto_last", last, 40);
        check("auto_spacing", bad, 0);
        check("auto_cnt", int'(step_cnt), 7);
        for (int i = 0; i < 3; i++) step_edge(0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step_edge(0, 0, 1);
            if (button) pulses++;
        end
        check("pause_pulses", pulses, 0);
        first = 0;
        for (int i = 1; i <= 12 && first == 0; i++) begin
            step_edge(0, 0, 0);
            if (button) first = i;
        end
        check("resume_latency", first, 5);
        check("resume_cnt", int'(step_cnt), 8);

        // 5: step press landing on the timer expiry edge gives one pulse
        first = 0; last = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            s = (i >= 5 && i <= 10);
            step_edge(0, s, 0);
            if (button) begin
                pulses++;
                if (first == 0) first = i;
                last = i;
            end
            if (i == 8) check("coincide_cnt", int'(step_cnt), 9);
        end
        check("coincide_pulses", pulses, 2);
        check("coincide_first", first, 8);
        check("coincide_next", last, 16);
        check("coincide_cnt_end", int'(step_cnt), 10);

        // 6: back to WHITE clears count, 256 manual steps wrap the counter
        for (int i = 0; i < 4; i++) step_edge(1, 0, 0);
        check("white_mode", int'(mode), 0);
        check("white_sel", int'(sel), 0);
        check("white_cnt", int'(step_cnt), 0);
        step_edge(0, 0, 0);
        for (int i = 0; i < 4; i++) step_edge(1, 0, 0);
        step_edge(0, 0, 0);
        check("manual_again", int'(mode), 1);
        pulses = 0;
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 3; j++) begin
                step_edge(0, 1, 0);
                if (button) pulses++;
            end
            step_edge(0, 0, 0);
            if (button) pulses++;
            if (k == 254) check("cnt_255", int'(step_cnt), 255);
        end
        check("wrap_pulses", pulses, 256);
        check("wrap_cnt", int'(step_cnt), 0);

        // simultaneous mode and step press: mode wins, step dropped
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step_edge(1, 1, 0);
            if (button) pulses++;
        end
        for (int i = 0; i < 2; i++) begin
            step_edge(0, 0, 0);
            if (button) pulses++;
        end
        check("simul_pulses", pulses, 0);
        check("simul_mode", int'(mode), 2);
        check("simul_cnt", int'(step_cnt), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step_edge(0, 0, 0);
            if (button) pulses++;
        end
        check("auto2_pulses", pulses, 1);
        check("auto2_cnt", int'(step_cnt), 1);

        // reset mid-AUTO
        rst = 1'b1;
        step_edge(0, 0, 0);
        check("rst_mode", int'(mode), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_button", int'(button), 0);
        check("rst_cnt", int'(step_cnt), 0);
        rst = 1'b0;
        step_edge(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
